// File: rtl/cache_pkg.sv
`default_nettype none
// ======================================================================
// cache_pkg: shared types and helpers for the wb_cache_ctrl slice (rev 1.0)
// ======================================================================
package cache_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TAG_CHK   = 3'd1,
    WB        = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4,
    INSTALL   = 3'd5
  } cache_state_t;

  function automatic int calc_tag_w(input int addr_w, input int idx_w);
    return addr_w - idx_w;
  endfunction

  function automatic int calc_lines(input int idx_w);
    return 1 << idx_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_line_array.sv
`default_nettype none
// ======================================================================
// cache_line_array: tag/valid/dirty/data storage, one write port, async read (rev 1.0)
// ======================================================================
module cache_line_array
  import cache_pkg::*;
#(
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_wdirty,
  input  logic [IDX_W-1:0]  i_ridx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data
);

  localparam int LINES = calc_lines(IDX_W);

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  // Every write installs or updates a resident line, so valid is always set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
      r_dirty[i_widx] <= i_wdirty;
      r_tag[i_widx]   <= i_wtag;
      r_data[i_widx]  <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_dirty = r_dirty[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_data  = r_data[i_ridx];

endmodule
`default_nettype wire

// File: rtl/wb_cache_ctrl.sv
`default_nettype none
// ======================================================================
// wb_cache_ctrl: direct-mapped write-back/write-allocate cache controller (rev 1.0)
// Optional hit/miss/write-back counters when CACHE_STATS_EN is defined.
// ======================================================================
module wb_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_req_we,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [STATS_W-1:0] hit_cnt,
  output logic [STATS_W-1:0] miss_cnt,
  output logic [STATS_W-1:0] wb_cnt
`endif
);

  localparam int TAG_W = calc_tag_w(ADDR_W, IDX_W);

  cache_state_t      r_state;
  cache_state_t      w_next;

  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_fill_data;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_line_valid;
  logic              w_line_dirty;
  logic [TAG_W-1:0]  w_line_tag;
  logic [DATA_W-1:0] w_line_data;
  logic              w_hit;

  logic              w_arr_we;
  logic [DATA_W-1:0] w_arr_data;
  logic              w_arr_dirty;
  logic              w_rsp_set;
  logic [DATA_W-1:0] w_rsp_data;
  logic              w_fill_cap;
  logic              w_accept;

  assign w_idx    = r_addr[IDX_W-1:0];
  assign w_tag    = r_addr[ADDR_W-1:IDX_W];
  assign w_hit    = w_line_valid && (w_line_tag == w_tag);
  assign w_accept = cpu_req_valid && (r_state == IDLE);

  cache_line_array #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_lines (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_arr_we),
    .i_widx   (w_idx),
    .i_wtag   (w_tag),
    .i_wdata  (w_arr_data),
    .i_wdirty (w_arr_dirty),
    .i_ridx   (w_idx),
    .o_valid  (w_line_valid),
    .o_dirty  (w_line_dirty),
    .o_tag    (w_line_tag),
    .o_data   (w_line_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Memory-side outputs decode straight from state, so an async reset of
  // the state register drops mem_req_valid without waiting for an edge.
  always_comb begin
    w_next        = r_state;
    w_arr_we      = 1'b0;
    w_arr_data    = r_wdata;
    w_arr_dirty   = 1'b0;
    w_rsp_set     = 1'b0;
    w_rsp_data    = r_rsp_rdata;
    w_fill_cap    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (r_state)
      IDLE: begin
        if (cpu_req_valid) w_next = TAG_CHK;
      end
      TAG_CHK: begin
        if (w_hit) begin
          w_rsp_set = 1'b1;
          if (r_we) begin
            w_arr_we    = 1'b1;
            w_arr_dirty = 1'b1;
            w_rsp_data  = r_wdata;
          end else begin
            w_rsp_data  = w_line_data;
          end
          w_next = IDLE;
        end else if (w_line_valid && w_line_dirty) begin
          w_next = WB;
        end else begin
          w_next = r_we ? INSTALL : FILL_REQ;
        end
      end
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {w_line_tag, w_idx};
        mem_req_wdata = w_line_data;
        if (mem_req_ready) w_next = r_we ? INSTALL : FILL_REQ;
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = r_addr;
        if (mem_req_ready) w_next = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_rsp_valid) begin
          w_fill_cap = 1'b1;
          w_next     = INSTALL;
        end
      end
      INSTALL: begin
        // A write miss replaces the whole one-word line, so no refill is needed.
        w_arr_we    = 1'b1;
        w_arr_data  = r_we ? r_wdata : r_fill_data;
        w_arr_dirty = r_we;
        w_rsp_set   = 1'b1;
        w_rsp_data  = w_arr_data;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_fill_data <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= cpu_req_addr;
        r_we    <= cpu_req_we;
        r_wdata <= cpu_req_wdata;
      end
      if (w_fill_cap) r_fill_data <= mem_rsp_rdata;
      r_rsp_valid <= w_rsp_set;
      if (w_rsp_set) r_rsp_rdata <= w_rsp_data;
    end
  end

  assign cpu_req_ready = (r_state == IDLE);
  assign cpu_rsp_valid = r_rsp_valid;
  assign cpu_rsp_rdata = r_rsp_rdata;

`ifdef CACHE_STATS_EN
  logic [STATS_W-1:0] r_hit_cnt;
  logic [STATS_W-1:0] r_miss_cnt;
  logic [STATS_W-1:0] r_wb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_state == TAG_CHK && w_hit && r_hit_cnt != '1)
        r_hit_cnt <= r_hit_cnt + 1'b1;
      if (r_state == TAG_CHK && !w_hit && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + 1'b1;
      if (r_state == WB && mem_req_ready && r_wb_cnt != '1)
        r_wb_cnt <= r_wb_cnt + 1'b1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_cache_ctrl.sv
`default_nettype none
// ======================================================================
// tb_wb_cache_ctrl: randomized self-checking bench against a flat-memory reference (rev 1.0)
// ======================================================================
module tb_wb_cache_ctrl;

  localparam int LINES = 4;

  logic        clk;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_we;
  logic [7:0]  cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [7:0]  mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] wb_cnt;
`endif

  wb_cache_ctrl #(.ADDR_W(8), .DATA_W(32), .IDX_W(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_we    (cpu_req_we),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_wdata (cpu_req_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rsp_rdata (cpu_rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  int          checks;
  int          failures;
  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [31:0] mem_arr [256];
  logic [31:0] arch    [256];
  bit          bp;
  bit          slow;

  // Reference: arch[] is what every address must read as; the slots only
  // record which address is resident and whether it still differs from memory.
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [7:0]  m_addr  [LINES];

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) arch[i] = mem_arr[i];
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_addr[i]  = 8'h00;
    end
  endfunction

  function automatic void model_access(input bit we, input logic [7:0] a, input logic [31:0] d,
                                       output bit hit, output logic [31:0] exp_rd);
    int slot;
    slot = int'(a) % LINES;
    exp_q.delete();
    hit = m_valid[slot] && (m_addr[slot] == a);
    if (!hit) begin
      if (m_valid[slot] && m_dirty[slot])
        exp_q.push_back({1'b1, m_addr[slot], arch[m_addr[slot]]});
      if (!we) exp_q.push_back({1'b0, a, 32'h0});
      m_valid[slot] = 1'b1;
      m_dirty[slot] = 1'b0;
      m_addr[slot]  = a;
    end
    if (we) begin
      arch[a]       = d;
      m_dirty[slot] = 1'b1;
    end
    exp_rd = arch[a];
  endfunction

  function automatic bit txns_match();
    if (log_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) begin
      if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr) return 1'b0;
      if (exp_q[i].we && log_q[i].data !== exp_q[i].data) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Memory responder: inputs change just after posedge, handshakes are
  // observed at negedge, response arrives at least one cycle after handshake.
  initial begin : memory_responder
    int         pend;
    logic [31:0] pend_data;
    pend = 0;
    pend_data = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      if (!rst_n) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = pend_data;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = $urandom;
      end
      mem_req_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (rst_n && mem_req_valid && mem_req_ready) begin
        if (mem_req_we) begin
          log_q.push_back({1'b1, mem_req_addr, mem_req_wdata});
          mem_arr[mem_req_addr] = mem_req_wdata;
        end else begin
          log_q.push_back({1'b0, mem_req_addr, 32'h0});
          pend      = slow ? 8 : int'($urandom_range(1, 3));
          pend_data = mem_arr[mem_req_addr];
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic do_op(input bit we, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int lat, output bit rdy_at_rsp);
    int n;
    log_q.delete();
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = a;
    cpu_req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cpu_req_ready) begin
      failures++;
      $display("FAIL accept_timeout: ready=%b required=1 addr=%h", cpu_req_ready, a);
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!cpu_rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!cpu_rsp_valid) begin
      failures++;
      $display("FAIL rsp_timeout: rsp_valid=%b required=1 addr=%h", cpu_rsp_valid, a);
    end
    rd         = cpu_rsp_rdata;
    rdy_at_rsp = cpu_req_ready;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[8'h05] = 32'h12345678;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cpu_rsp_valid !== 1'b0 || cpu_rsp_rdata !== 32'h0 || mem_req_valid !== 1'b0 ||
        mem_req_we !== 1'b0 || mem_req_addr !== 8'h00 || mem_req_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: rsp_v=%b rdata=%h mreq_v=%b we=%b addr=%h wdata=%h required all 0",
               cpu_rsp_valid, cpu_rsp_rdata, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b required 1", cpu_req_ready);
    end
  endtask

  task automatic test_directed();
    bit          t_we  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  t_adr [6] = '{8'h05, 8'h05, 8'h05, 8'h09, 8'h0A, 8'h0A};
    logic [31:0] t_dat [6] = '{32'h0, 32'h0, 32'hCAFEBABE, 32'h0, 32'hDEADBEEF, 32'h0};
    bit          t_hit [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] t_rd  [6] = '{32'h12345678, 32'h12345678, 32'hCAFEBABE, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF};
    for (int i = 0; i < 6; i++) begin
      logic [31:0] rd, exp_rd;
      int          lat;
      bit          rdy, hit;
      model_access(t_we[i], t_adr[i], t_dat[i], hit, exp_rd);
      do_op(t_we[i], t_adr[i], t_dat[i], rd, lat, rdy);
      checks++;
      if (rd !== exp_rd || (i != 3 && rd !== t_rd[i])) begin
        failures++;
        $display("FAIL dir_rdata[%0d]: got %h required %h", i, rd, exp_rd);
      end
      checks++;
      if (t_hit[i] ? (lat != 2) : (lat <= 2)) begin
        failures++;
        $display("FAIL dir_latency[%0d]: got %0d hit_required=%0b", i, lat, t_hit[i]);
      end
      checks++;
      if (!txns_match()) begin
        failures++;
        $display("FAIL dir_mem_txns[%0d]: got %0d txns required %0d", i, log_q.size(), exp_q.size());
      end
    end
    checks++;
    if (mem_arr[8'h05] !== 32'hCAFEBABE) begin
      failures++;
      $display("FAIL dir_writeback_mem: mem[05]=%h required cafebabe", mem_arr[8'h05]);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_rd;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_we;
    bit          hit;
    int          n;
    model_access(1'b0, 8'h30, 32'h0, hit, exp_rd);
    log_q.delete();
    bp = 1'b1;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 8'h30;
    cpu_req_wdata = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_req_we    = 1'b1;
    cpu_req_addr  = 8'h41;
    cpu_req_wdata = 32'h55AA55AA;
    n = 0;
    @(negedge clk);
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    s_addr  = mem_req_addr;
    s_we    = mem_req_we;
    s_wdata = mem_req_wdata;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== s_addr || mem_req_we !== s_we ||
          mem_req_wdata !== s_wdata || cpu_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall[%0d]: valid=%b addr=%h we=%b ready=%b required 1/%h/%b/0",
                 c, mem_req_valid, mem_req_addr, mem_req_we, cpu_req_ready, s_addr, s_we);
      end
    end
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    bp = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cpu_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== exp_rd) begin
      failures++;
      $display("FAIL bp_rsp: valid=%b rdata=%h required 1/%h", cpu_rsp_valid, cpu_rsp_rdata, exp_rd);
    end
    checks++;
    if (!txns_match()) begin
      failures++;
      $display("FAIL bp_mem_txns: got %0d txns required %0d", log_q.size(), exp_q.size());
    end
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cpu_rsp_valid) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL bp_ignored_req: got %0d extra responses required 0", n);
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd, exp_rd;
    int          lat, n;
    bit          rdy, hit;
    model_access(1'b0, 8'h13, 32'h0, hit, exp_rd);
    do_op(1'b0, 8'h13, 32'h0, rd, lat, rdy);
    checks++;
    if (rd !== exp_rd) begin
      failures++;
      $display("FAIL rmr_prefill: got %h required %h", rd, exp_rd);
    end
    slow = 1'b1;
    log_q.delete();
    @(posedge clk); #1;
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 8'h20;
    @(negedge clk);
    @(posedge clk); #1;
    cpu_req_valid = 1'b0;
    n = 0;
    while (!(log_q.size() > 0 && log_q[log_q.size()-1].we == 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmr_async_drop: mreq_v=%b rsp_v=%b required 0/0", mem_req_valid, cpu_rsp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    slow  = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (cpu_req_ready !== 1'b1 || cpu_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmr_release: ready=%b rsp_v=%b required 1/0", cpu_req_ready, cpu_rsp_valid);
    end
    model_access(1'b0, 8'h13, 32'h0, hit, exp_rd);
    do_op(1'b0, 8'h13, 32'h0, rd, lat, rdy);
    checks++;
    if (lat <= 2 || !txns_match() || rd !== exp_rd) begin
      failures++;
      $display("FAIL rmr_remiss: lat=%0d txns=%0d rdata=%h required miss/%0d/%h",
               lat, log_q.size(), rd, exp_q.size(), exp_rd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic [31:0] rd, exp_rd, d;
      logic [7:0]  a;
      int          lat;
      bit          rdy, hit, we;
      we = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d  = $urandom;
      model_access(we, a, d, hit, exp_rd);
      do_op(we, a, d, rd, lat, rdy);
      checks++;
      if (rd !== exp_rd) begin
        failures++;
        $display("FAIL rnd_rdata[%0d]: addr=%h we=%b got %h required %h", i, a, we, rd, exp_rd);
      end
      checks++;
      if (hit ? (lat != 2) : (lat <= 2)) begin
        failures++;
        $display("FAIL rnd_latency[%0d]: got %0d hit_required=%0b", i, lat, hit);
      end
      checks++;
      if (rdy !== 1'b1) begin
        failures++;
        $display("FAIL rnd_ready_at_rsp[%0d]: got %b required 1", i, rdy);
      end
      checks++;
      if (!txns_match()) begin
        failures++;
        $display("FAIL rnd_mem_txns[%0d]: got %0d txns required %0d", i, log_q.size(), exp_q.size());
      end
    end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    bit          s_we  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0]  s_adr [4] = '{8'h05, 8'h05, 8'h05, 8'h09};
    do_reset();
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || wb_cnt !== 16'd0) begin
      failures++;
      $display("FAIL stats_reset: hit=%0d miss=%0d wb=%0d required 0/0/0", hit_cnt, miss_cnt, wb_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rd, exp_rd;
      int          lat;
      bit          rdy, hit;
      model_access(s_we[i], s_adr[i], 32'hCAFEBABE, hit, exp_rd);
      do_op(s_we[i], s_adr[i], 32'hCAFEBABE, rd, lat, rdy);
    end
    @(negedge clk);
    checks++;
    if (hit_cnt !== 16'd2 || miss_cnt !== 16'd2 || wb_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stats_counts: hit=%0d miss=%0d wb=%0d required 2/2/1", hit_cnt, miss_cnt, wb_cnt);
    end
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    bp            = 1'b0;
    slow          = 1'b0;
    rst_n         = 1'b0;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = '0;
    cpu_req_wdata = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_refill();
    test_random();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
